// File: rtl/byte_serializer_pkg.sv
// Shared constants for the byte serializer: FSM encoding and default geometry.
package byte_serializer_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_CE_DIV = 4;

endpackage

// File: rtl/byte_serializer_ce_divider.sv
// Clock-enable divider: o_tick is high in the cycle whose closing edge takes the count to 0.
// Runs from i_load until i_reset; reload to DIV-1 on reaching 0, never wraps.
module ce_divider
   import byte_serializer_pkg::*;
#(
   parameter int DIV = DEF_CE_DIV
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_load,
   output logic o_tick
);

   localparam int               CW     = $clog2(DIV + 1);
   localparam logic [CW-1:0]    RELOAD = CW'(DIV - 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          run;
   logic          run_nxt;

   // The tick is decoded from the next count so a registered consumer lines up with the zero.
   always_comb begin
      run_nxt = run | i_load;
      cnt_nxt = '0;
      if (i_load) begin
         cnt_nxt = RELOAD;
      end else if (run) begin
         cnt_nxt = (cnt == '0) ? RELOAD : cnt - 1'b1;
      end
      o_tick = run_nxt && (cnt_nxt == '0);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt <= '0;
         run <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         run <= run_nxt;
      end
   end

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial shifter: one word per accept, one bit per divider tick, all outputs registered.
// i_stb is ignored while o_busy; o_done pulses alongside the final o_ce.
module byte_serializer
   import byte_serializer_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int CE_DIV    = DEF_CE_DIV,
   parameter int LSB_FIRST = 0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_stb,
   input  logic [WIDTH-1:0] i_word,
   output logic             o_busy,
   output logic             o_ce,
   output logic             o_data,
   output logic             o_done
);

   localparam int BW = $clog2(WIDTH + 1);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] word_q;
   logic [WIDTH-1:0] word_nxt;
   logic [BW-1:0]    bit_cnt;
   logic [BW-1:0]    bit_cnt_nxt;
   logic [BW-1:0]    cur_cnt;
   logic [WIDTH-1:0] src_word;
   logic [IW-1:0]    idx;
   logic             sel_bit;
   logic             accept;
   logic             tick;
   logic             stop;
   logic             div_reset;
   logic             busy_nxt;
   logic             ce_nxt;
   logic             data_nxt;
   logic             done_nxt;

   always_comb begin
      accept = (state == ST_IDLE) && i_stb;
   end

   ce_divider #(
      .DIV (CE_DIV)
   ) u_div (
      .i_clk   (i_clk),
      .i_reset (div_reset),
      .i_load  (accept),
      .o_tick  (tick)
   );

   // With CE_DIV=1 the first bit leaves on the accept edge, so read straight from i_word then.
   always_comb begin
      cur_cnt   = accept ? '0 : bit_cnt;
      src_word  = accept ? i_word : word_q;
      idx       = (LSB_FIRST != 0) ? cur_cnt[IW-1:0] : IW'(WIDTH - 1) - cur_cnt[IW-1:0];
      sel_bit   = src_word[idx];
      stop      = tick && (cur_cnt == BW'(WIDTH - 1));
      div_reset = i_reset | stop;

      state_nxt   = state;
      word_nxt    = word_q;
      bit_cnt_nxt = tick ? cur_cnt + 1'b1 : cur_cnt;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = ST_SHIFT;
               word_nxt  = i_word;
            end
         end
         ST_SHIFT: begin
            if (bit_cnt == BW'(WIDTH)) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (state_nxt == ST_IDLE) begin
         bit_cnt_nxt = '0;
      end

      busy_nxt = (state_nxt == ST_SHIFT);
      ce_nxt   = tick;
      done_nxt = stop;
      data_nxt = o_data;
      if (state_nxt == ST_IDLE) begin
         data_nxt = 1'b0;
      end else if (tick) begin
         data_nxt = sel_bit;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state   <= ST_IDLE;
         word_q  <= '0;
         bit_cnt <= '0;
         o_busy  <= 1'b0;
         o_ce    <= 1'b0;
         o_data  <= 1'b0;
         o_done  <= 1'b0;
      end else begin
         state   <= state_nxt;
         word_q  <= word_nxt;
         bit_cnt <= bit_cnt_nxt;
         o_busy  <= busy_nxt;
         o_ce    <= ce_nxt;
         o_data  <= data_nxt;
         o_done  <= done_nxt;
      end
   end

`ifdef FORMAL
   a_ce_needs_busy : assert property (@(posedge i_clk) disable iff (i_reset) o_ce |-> o_busy);
   a_done_with_ce  : assert property (@(posedge i_clk) disable iff (i_reset) o_done |-> o_ce);
   a_done_count    : assert property (@(posedge i_clk) disable iff (i_reset) o_done |-> bit_cnt == BW'(WIDTH));
   a_count_bound   : assert property (@(posedge i_clk) bit_cnt <= BW'(WIDTH));
   a_exit_on_done  : assert property (@(posedge i_clk)
                                      ($fell(o_busy) && !$past(i_reset)) |-> $past(o_done));
`endif

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of bits per word.
REQ-002 SHALL have parameter CE_DIV, default 4: clock cycles per serial bit; legal range 1..65535.
REQ-003 SHALL have parameter LSB_FIRST, default 0: 0 sends MSB first, 1 sends LSB first.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock, rising-edge.
REQ-005 SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port i_stb, input, 1 bit: a word is offered on i_word.
REQ-007 SHALL have port i_word, input, WIDTH bits: parallel word to serialize.
REQ-008 SHALL have port o_busy, output, 1 bit: a word is in flight and i_stb is ignored.
REQ-009 SHALL have port o_ce, output, 1 bit: a serial-bit strobe; drives downstream i_ce.
REQ-010 SHALL have port o_data, output, 1 bit: the serial bit; drives downstream i_data.
REQ-011 SHALL have port o_done, output, 1 bit: one-cycle pulse with the final bit's o_ce.

Function
REQ-012 SHALL implement two states, IDLE and SHIFT; all outputs SHALL be registered.
REQ-013 In IDLE, i_stb=1 at edge t SHALL capture i_word and enter SHIFT, so o_busy=1 from cycle t+1.
REQ-014 In SHIFT, i_stb SHALL be ignored and the captured word SHALL be unaffected by i_word.
REQ-015 A divider SHALL load CE_DIV-1 on accept, decrement once per cycle, and reload CE_DIV-1 when it reaches 0.
REQ-016 o_ce SHALL be 1 for exactly one cycle each time the divider reaches 0, so the first o_ce occurs in cycle t+CE_DIV.
REQ-017 o_data SHALL carry bit k of the captured word in the cycle of the k-th o_ce (k=0..WIDTH-1), with ordering set by LSB_FIRST.
REQ-018 After the WIDTH-th o_ce, in cycle t+WIDTH*CE_DIV, o_done SHALL be 1 in that same cycle, and the block SHALL return to IDLE so that o_busy=0 in cycle t+WIDTH*CE_DIV+1.
REQ-019 o_data SHALL hold its value in cycles where o_ce=0.
REQ-020 o_data SHALL be 0 in IDLE.
REQ-021 With CE_DIV=1, o_ce SHALL be 1 on WIDTH consecutive cycles, t+1 through t+WIDTH.
REQ-022 Back-to-back words SHALL be accepted as early as the first IDLE cycle, giving a minimum gap of CE_DIV cycles between the last o_ce of one word and the first o_ce of the next.
REQ-023 The bit counter SHALL be sized clog2(WIDTH+1) and SHALL never wrap within a word.
REQ-024 The divider SHALL be sized clog2(CE_DIV+1) and SHALL never wrap.

Reset
REQ-025 i_reset=1 at any edge SHALL force IDLE, o_busy=0, o_ce=0, o_data=0 and o_done=0 in the following cycle.
REQ-026 Reset SHALL take priority over a simultaneous i_stb.
REQ-027 Reset mid-word SHALL discard the word with no further o_ce.
REQ-028 Initial values SHALL equal the reset values.

Structure
REQ-029 State encodings (IDLE=0, SHIFT=1) SHALL live in the shared project constants package/include, together with the default WIDTH and CE_DIV.
REQ-030 The divider SHALL be a sub-module named ce_divider (inputs i_clk, i_reset, i_load; output o_tick), reusable by other stages.
REQ-031 Formal properties under FORMAL SHALL check:
- o_ce never asserts while o_busy=0;
- exactly WIDTH o_ce pulses occur per accepted word;
- o_done implies o_ce.

Verification
REQ-032 Scenario, single word (WIDTH=8, CE_DIV=4): i_word=8'hA5, i_stb at cycle 0 -> o_ce at cycles 4,8,...,32; o_data=1,0,1,0,0,1,0,1; o_done at 32; o_busy=0 at 33.
REQ-033 Scenario, LSB first: same stimulus with LSB_FIRST=1 -> o_data sequence 1,0,1,0,0,1,0,1 reversed (1,0,1,0,0,1,0,1 for palindromic 8'hA5); then i_word=8'h01 -> first bit 1, then seven 0s.
REQ-034 Scenario, busy ignore: i_stb=1 with i_word=8'hFF at cycle 5 while busy -> serial stream still 8'hA5; no second word sent.
REQ-035 Scenario, back-to-back: i_stb held high -> second word accepted at cycle 33; its first o_ce at cycle 37.
REQ-036 Scenario, reset mid-word: i_reset=1 at cycle 14 -> o_busy, o_ce and o_data=0 from cycle 15; no o_done.
REQ-037 Scenario, CE_DIV=1, i_word=8'h81: o_ce on cycles 1..8; o_data=1,0,0,0,0,0,0,1; o_done at cycle 8.
